multicycle_seq_ctrl: RTL

//  Multi-cycle sequencer for the RV32 datapath. Fetches each instruction over an

---
 rtl/rv_ctrl_pkg.sv | 41 ++++
 rtl/multicycle_seq_ctrl_ack_timeout_cnt.sv | 29 ++
 rtl/multicycle_seq_ctrl.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/rv_ctrl_pkg.sv
// Shared definitions for the multi-cycle RV32 sequencer: opcode constants,
// FSM state encoding and the instruction class produced by decode.
package rv_ctrl_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_MEM,
        ST_WB,
        ST_TRAP
    } state_t;

    typedef enum logic [2:0] {
        CLS_R,
        CLS_I,
        CLS_LOAD,
        CLS_STORE,
        CLS_BRANCH,
        CLS_ILLEGAL
    } instr_class_t;

    // Map the major opcode field onto the instruction class.
    function automatic instr_class_t classify(input logic [6:0] opcode);
        case (opcode)
            OP_R:      classify = CLS_R;
            OP_I:      classify = CLS_I;
            OP_LOAD:   classify = CLS_LOAD;
            OP_STORE:  classify = CLS_STORE;
            OP_BRANCH: classify = CLS_BRANCH;
            default:   classify = CLS_ILLEGAL;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_seq_ctrl_ack_timeout_cnt.sv
// Wait-cycle counter for memory handshakes. Counts cycles where a request is
// outstanding and not acked; flags expiry on the MEM_TIMEOUT-th such cycle.
module ack_timeout_cnt #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 5
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [CNT_W-1:0] count;

    // Count un-acked waiting cycles; cleared whenever no handshake is pending.
    always_ff @(posedge clk) begin
        // NOTE: registers are updated with <= so every flop samples pre-edge values.
        if (reset || clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    // An ack in the final allowed cycle clears enable, so the ack wins.
    assign expired = enable && (count == CNT_W'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/multicycle_seq_ctrl.sv
// Multi-cycle sequencer: fetches into IR over a req/ack handshake, walks each
// instruction through DECODE/EXEC/MEM/WB, and owns PC and the retired count.
module multicycle_seq_ctrl
    import rv_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          MEM_TIMEOUT = 16,
    parameter int          CNT_W       = 5
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        dmem_req,
    output logic        dmem_we,
    input  logic        dmem_ack,
    input  logic        jump_flag,
    input  logic [31:0] br_offset,
    output logic [31:0] ir,
    output logic [31:0] pc,
    output logic        regwrite_en,
    output logic        wb_sel,
    output logic        trap,
    output logic [31:0] retired
);

    state_t       state;
    instr_class_t cls;
    instr_class_t decoded_cls;
    logic         br_taken;
    logic [31:0]  br_off;
    logic         tmo_clear;
    logic         tmo_enable;
    logic         tmo_expired;

    assign imem_addr   = pc;
    assign decoded_cls = classify(ir[6:0]);

    // Only FETCH and MEM wait on an ack; any other state keeps the counter at zero,
    // so it starts clean on every entry to a waiting state.
    assign tmo_clear  = (state != ST_FETCH) && (state != ST_MEM);
    assign tmo_enable = ((state == ST_FETCH) && imem_req && !imem_ack) ||
                        ((state == ST_MEM)   && dmem_req && !dmem_ack);

    ack_timeout_cnt #(
        .MEM_TIMEOUT (MEM_TIMEOUT),
        .CNT_W       (CNT_W)
    ) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .clear   (tmo_clear),
        .enable  (tmo_enable),
        .expired (tmo_expired)
    );

    // Sequencer FSM with registered handshake, strobe and architectural state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_FETCH;
            cls         <= CLS_R;
            pc          <= RESET_PC;
            ir          <= '0;
            retired     <= '0;
            imem_req    <= 1'b0;
            dmem_req    <= 1'b0;
            dmem_we     <= 1'b0;
            regwrite_en <= 1'b0;
            wb_sel      <= 1'b0;
            trap        <= 1'b0;
            br_taken    <= 1'b0;
            br_off      <= '0;
        end else begin
            case (state)
                ST_FETCH: begin
                    // Right after reset the request is still low; raise it first
                    // so any stray ack from before reset is ignored.
                    if (!imem_req) begin
                        imem_req <= 1'b1;
                    end else if (imem_ack) begin
                        ir       <= imem_rdata;
                        imem_req <= 1'b0;
                        state    <= ST_DECODE;
                    end else if (tmo_expired) begin
                        imem_req <= 1'b0;
                        trap     <= 1'b1;
                        state    <= ST_TRAP;
                    end
                end
                ST_DECODE: begin
                    cls <= decoded_cls;
                    if (decoded_cls == CLS_ILLEGAL) begin
                        trap  <= 1'b1;
                        state <= ST_TRAP;
                    end else begin
                        state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    br_taken <= (cls == CLS_BRANCH) && jump_flag;
                    br_off   <= br_offset;
                    if ((cls == CLS_LOAD) || (cls == CLS_STORE)) begin
                        dmem_req <= 1'b1;
                        dmem_we  <= (cls == CLS_STORE);
                        state    <= ST_MEM;
                    end else begin
                        regwrite_en <= (cls == CLS_R) || (cls == CLS_I);
                        wb_sel      <= 1'b0;
                        state       <= ST_WB;
                    end
                end
                ST_MEM: begin
                    if (dmem_ack) begin
                        dmem_req    <= 1'b0;
                        dmem_we     <= 1'b0;
                        regwrite_en <= (cls == CLS_LOAD);
                        wb_sel      <= (cls == CLS_LOAD);
                        state       <= ST_WB;
                    end else if (tmo_expired) begin
                        dmem_req <= 1'b0;
                        dmem_we  <= 1'b0;
                        trap     <= 1'b1;
                        state    <= ST_TRAP;
                    end
                end
                ST_WB: begin
                    regwrite_en <= 1'b0;
                    wb_sel      <= 1'b0;
                    pc          <= br_taken ? (pc + br_off) : (pc + 32'd4);
                    retired     <= retired + 32'd1;
                    imem_req    <= 1'b1;
                    state       <= ST_FETCH;
                end
                ST_TRAP: begin
                    imem_req <= 1'b0;
                    dmem_req <= 1'b0;
                    dmem_we  <= 1'b0;
                    trap     <= 1'b1;
                end
                default: begin
                    imem_req <= 1'b0;
                    dmem_req <= 1'b0;
                    dmem_we  <= 1'b0;
                    trap     <= 1'b1;
                    state    <= ST_TRAP;
                end
            endcase
        end
    end

endmodule
